drive_z_corr_table_loader: RTL and testbench
============================================

// Module: drive_z_corr_table_loader
// PURPOSE
//  Write-side companion of the drive z-correction table. Takes a narrow valid/ready stream of per-qubit
//  Z_CORR_WIDTH coefficients and assembles it into full DATA_WIDTH table rows.
//  Issues row writes on the z_corr_memory_wr_* interface to one or more banks.
//  Sits between the host/config sequencer and the table; runs only while the drive pipeline is idle (ld_busy gates issue).
// PARAMETERS
//  NUM_BANK                   2   number of table banks
//  NUM_QUBIT_PER_BANK        16   entries per bank (NUM_ENTRY)
//  QUBIT_ADDR_WIDTH_PER_BANK  4   ADDR_WIDTH; NUM_ENTRY == 2**ADDR_WIDTH
//  Z_CORR_WIDTH              12   coefficient width
//  derived: TOTAL_QUBIT=NUM_BANK*NUM_QUBIT_PER_BANK; DATA_WIDTH=Z_CORR_WIDTH*TOTAL_QUBIT; CNT_W=$clog2(TOTAL_QUBIT)
// PORTS
//  clk                    in   1              clock; single clock domain
//  rst                    in   1              synchronous, active-high reset
//  ld_start               in   1              1-cycle start pulse; sampled only in IDLE
//  ld_bank_sel            in   NUM_BANK       one-hot or multi-hot target bank mask (multi = broadcast)
//  ld_base_addr           in   ADDR_WIDTH     first entry written
//  ld_num_entry           in   ADDR_WIDTH+1   rows to write, 0..NUM_ENTRY
//  coef_valid             in   1              coefficient stream valid
//  coef_ready             out  1              coefficient stream ready
//  coef_data              in   Z_CORR_WIDTH   coefficient, qubit 0 first
//  z_corr_memory_wr_sel   out  NUM_BANK       bank mask; equals latched ld_bank_sel while wr_en=1, else 0
//  z_corr_memory_wr_en    out  1              row write strobe, 1 cycle per row
//  z_corr_memory_wr_addr  out  ADDR_WIDTH     row address
//  z_corr_memory_wr_data  out  DATA_WIDTH     assembled row; qubit q at [q*Z_CORR_WIDTH +: Z_CORR_WIDTH]
//  ld_busy                out  1              high in any state except IDLE
//  ld_done                out  1              1-cycle completion pulse
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output and of the row buffer is 0; state is IDLE.
//  - FSM states: IDLE, FILL, WRITE, DONE.
//    IDLE->FILL : ld_start, mask!=0, num!=0. Latch mask, addr=base, remaining=min(num,NUM_ENTRY), word_cnt=0.
//    IDLE->DONE : ld_start with mask==0 or num==0. No stream words are consumed and no write is issued.
//    FILL       : coef_ready=1. Each valid&ready places coef_data at row slot word_cnt and increments word_cnt.
//                 Accepting word_cnt==TOTAL_QUBIT-1 moves to WRITE.
//    WRITE      : coef_ready=0. wr_en=1 for exactly 1 cycle with the full row. remaining-1.
//                 If remaining becomes 0 -> DONE; else -> FILL with word_cnt=0 and addr=addr+1.
//    DONE       : ld_done=1 for 1 cycle, then -> IDLE.
//  - Latency: last word accepted at cycle N -> wr_en high at N+1 -> ld_done at N+2 (final row).
//  - Address wrap: addr increments modulo NUM_ENTRY (15 -> 0). A run never writes more than NUM_ENTRY rows.
//  - ld_num_entry > NUM_ENTRY is clamped to NUM_ENTRY.
//  - ld_start outside IDLE is ignored; the in-flight operation is unaffected.
//  - coef_valid outside FILL is not accepted (coef_ready=0); stream data is held by the producer.
//  - Stalls: coef_valid low in FILL simply waits, with no timeout. Partial rows are never written.
//  - Reset mid-operation aborts immediately: no wr_en issued, no ld_done pulse, buffer cleared.
//  - Arithmetic: counters are unsigned. coef_data is stored verbatim; no sign extension or saturation.
// CONFIGURATION
//  Macro DRIVE_Z_CORR_LOADER_CLEAR_EN:
//  - Defined: adds input ld_clear (1 bit, sampled with ld_start) and state CLEAR.
//    ld_start&ld_clear (mask!=0, num!=0) -> CLEAR.
//    CLEAR writes wr_data=0, one row per cycle, at consecutive (wrapping) addresses for the clamped count.
//    coef_ready stays 0 throughout. Then DONE -> ld_done.
//    Clear of 16 rows: wr_en high 16 consecutive cycles, ld_done on cycle 17.
//  - Undefined: port and state are absent; stream loading only.
// STRUCTURE
//  - Shared package drive_circuit_pkg: FSM state encodings and derived widths
//    (TOTAL_QUBIT, DATA_WIDTH, CNT_W), shared with drive_z_corr_table.
//  - One sub-module z_corr_row_assembler: indexed slot-insert row buffer with word counter,
//    full flag and synchronous clear. The FSM, address and remaining counters stay in the top level.
// TESTING
//  1 Single row: mask=01, base=3, num=1, words 0x001..0x020 back-to-back -> one wr_en, sel=01, addr=3,
//    slot q = q+1; ld_done 2 cycles after word 32.
//  2 Broadcast + wrap: mask=11, base=14, num=4 -> writes at addr 14,15,0,1, sel=11 each; exactly 4 wr_en pulses.
//  3 Backpressure: coef_valid random 30% duty -> identical rows to test 1. No write before the 32nd word.
//    coef_ready=0 during WRITE.
//  4 Degenerate: num=0, and separately mask=00 -> ld_done 1 cycle after start. No wr_en; coef_ready never 1.
//    num=20 -> exactly 16 writes.
//  5 Reset/ignore: ld_start in FILL changes nothing. rst after word 10 -> all outputs 0 next cycle, no wr_en, no ld_done.
//  6 (CLEAR_EN) ld_clear=1, mask=10, base=0, num=16 -> 16 consecutive zero writes to addr 0..15, sel=10, then ld_done.

Source files
------------

// File: rtl/drive_circuit_pkg.sv
// Shared drive-circuit definitions: loader FSM states and default table geometry.
// State CLEAR exists only when DRIVE_Z_CORR_LOADER_CLEAR_EN is defined.
package drive_circuit_pkg;

  localparam int unsigned NUM_BANK                  = 2;
  localparam int unsigned NUM_QUBIT_PER_BANK        = 16;
  localparam int unsigned QUBIT_ADDR_WIDTH_PER_BANK = 4;
  localparam int unsigned Z_CORR_WIDTH              = 12;

  localparam int unsigned TOTAL_QUBIT = NUM_BANK * NUM_QUBIT_PER_BANK;
  localparam int unsigned DATA_WIDTH  = Z_CORR_WIDTH * TOTAL_QUBIT;
  localparam int unsigned CNT_W       = $clog2(TOTAL_QUBIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
`ifdef DRIVE_Z_CORR_LOADER_CLEAR_EN
    ST_CLEAR,
`endif
    ST_DONE
  } ld_state_t;

endpackage

// File: rtl/drive_z_corr_table_loader_row_assembler.sv
// Row buffer for the z-correction loader: inserts one coefficient per push at the
// slot named by the word counter; row_ins is the row as it stands after the current push.
module z_corr_row_assembler #(
  parameter int unsigned Z_CORR_WIDTH = drive_circuit_pkg::Z_CORR_WIDTH,
  parameter int unsigned TOTAL_QUBIT  = drive_circuit_pkg::TOTAL_QUBIT,
  parameter int unsigned CNT_W        = drive_circuit_pkg::CNT_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                push,
  input  logic [Z_CORR_WIDTH-1:0]             data,
  output logic [Z_CORR_WIDTH*TOTAL_QUBIT-1:0] row_ins,
  output logic                                full
);

  logic [Z_CORR_WIDTH*TOTAL_QUBIT-1:0] row;
  logic [CNT_W-1:0]                    word_cnt;

  assign full = (word_cnt == CNT_W'(TOTAL_QUBIT - 1));

  always_comb begin
    row_ins = row;
    for (int unsigned q = 0; q < TOTAL_QUBIT; q++) begin
      if (word_cnt == CNT_W'(q)) row_ins[q*Z_CORR_WIDTH +: Z_CORR_WIDTH] = data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row      <= '0;
      word_cnt <= '0;
    end else if (push) begin
      row      <= row_ins;
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/drive_z_corr_table_loader.sv
// Assembles a narrow coefficient stream into full z-correction rows and writes them
// to the selected banks. Optional zero-fill mode: DRIVE_Z_CORR_LOADER_CLEAR_EN.
module drive_z_corr_table_loader #(
  parameter int unsigned NUM_BANK                  = drive_circuit_pkg::NUM_BANK,
  parameter int unsigned NUM_QUBIT_PER_BANK        = drive_circuit_pkg::NUM_QUBIT_PER_BANK,
  parameter int unsigned QUBIT_ADDR_WIDTH_PER_BANK = drive_circuit_pkg::QUBIT_ADDR_WIDTH_PER_BANK,
  parameter int unsigned Z_CORR_WIDTH              = drive_circuit_pkg::Z_CORR_WIDTH
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  ld_start,
`ifdef DRIVE_Z_CORR_LOADER_CLEAR_EN
  input  logic                                                  ld_clear,
`endif
  input  logic [NUM_BANK-1:0]                                   ld_bank_sel,
  input  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0]                  ld_base_addr,
  input  logic [QUBIT_ADDR_WIDTH_PER_BANK:0]                    ld_num_entry,
  input  logic                                                  coef_valid,
  output logic                                                  coef_ready,
  input  logic [Z_CORR_WIDTH-1:0]                               coef_data,
  output logic [NUM_BANK-1:0]                                   z_corr_memory_wr_sel,
  output logic                                                  z_corr_memory_wr_en,
  output logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0]                  z_corr_memory_wr_addr,
  output logic [Z_CORR_WIDTH*NUM_BANK*NUM_QUBIT_PER_BANK-1:0]   z_corr_memory_wr_data,
  output logic                                                  ld_busy,
  output logic                                                  ld_done
);

  import drive_circuit_pkg::*;

  localparam int unsigned TOTAL_QUBIT = NUM_BANK * NUM_QUBIT_PER_BANK;
  localparam int unsigned DATA_WIDTH  = Z_CORR_WIDTH * TOTAL_QUBIT;
  localparam int unsigned CNT_W       = $clog2(TOTAL_QUBIT);
  localparam int unsigned AW          = QUBIT_ADDR_WIDTH_PER_BANK;
  localparam logic [AW:0] NUM_ENTRY   = (AW+1)'(NUM_QUBIT_PER_BANK);

  ld_state_t             state;
  logic [NUM_BANK-1:0]   sel_q;
  logic [AW-1:0]         addr_q;
  logic [AW:0]           remaining;
  logic [AW:0]           num_clamped;
  logic                  start_ok;
  logic                  accept;
  logic                  start_fill;
  logic                  row_full;
  logic [DATA_WIDTH-1:0] row_ins;

  always_comb begin
    num_clamped = (ld_num_entry > NUM_ENTRY) ? NUM_ENTRY : ld_num_entry;
    start_ok    = (ld_bank_sel != '0) && (ld_num_entry != '0);
    accept      = coef_valid && coef_ready;
    start_fill  = (state == ST_IDLE) && ld_start && start_ok;
  end

  z_corr_row_assembler #(
    .Z_CORR_WIDTH (Z_CORR_WIDTH),
    .TOTAL_QUBIT  (TOTAL_QUBIT),
    .CNT_W        (CNT_W)
  ) u_row_assembler (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_fill),
    .push    (accept),
    .data    (coef_data),
    .row_ins (row_ins),
    .full    (row_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= ST_IDLE;
      sel_q                 <= '0;
      addr_q                <= '0;
      remaining             <= '0;
      coef_ready            <= 1'b0;
      z_corr_memory_wr_sel  <= '0;
      z_corr_memory_wr_en   <= 1'b0;
      z_corr_memory_wr_addr <= '0;
      z_corr_memory_wr_data <= '0;
      ld_busy               <= 1'b0;
      ld_done               <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_start) begin
            ld_busy <= 1'b1;
            if (start_ok) begin
              sel_q     <= ld_bank_sel;
              addr_q    <= ld_base_addr;
              remaining <= num_clamped;
`ifdef DRIVE_Z_CORR_LOADER_CLEAR_EN
              if (ld_clear) begin
                state                 <= ST_CLEAR;
                z_corr_memory_wr_en   <= 1'b1;
                z_corr_memory_wr_sel  <= ld_bank_sel;
                z_corr_memory_wr_addr <= ld_base_addr;
                z_corr_memory_wr_data <= '0;
              end else begin
                state      <= ST_FILL;
                coef_ready <= 1'b1;
              end
`else
              state      <= ST_FILL;
              coef_ready <= 1'b1;
`endif
            end else begin
              state   <= ST_DONE;
              ld_done <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          // The final word goes straight into the outgoing row so wr_en follows it by one cycle.
          if (accept && row_full) begin
            state                 <= ST_WRITE;
            coef_ready            <= 1'b0;
            z_corr_memory_wr_en   <= 1'b1;
            z_corr_memory_wr_sel  <= sel_q;
            z_corr_memory_wr_addr <= addr_q;
            z_corr_memory_wr_data <= row_ins;
          end
        end
        ST_WRITE: begin
          z_corr_memory_wr_en  <= 1'b0;
          z_corr_memory_wr_sel <= '0;
          remaining            <= remaining - (AW+1)'(1);
          if (remaining == (AW+1)'(1)) begin
            state   <= ST_DONE;
            ld_done <= 1'b1;
          end else begin
            state      <= ST_FILL;
            addr_q     <= addr_q + AW'(1);
            coef_ready <= 1'b1;
          end
        end
`ifdef DRIVE_Z_CORR_LOADER_CLEAR_EN
        ST_CLEAR: begin
          remaining <= remaining - (AW+1)'(1);
          if (remaining == (AW+1)'(1)) begin
            state                <= ST_DONE;
            z_corr_memory_wr_en  <= 1'b0;
            z_corr_memory_wr_sel <= '0;
            ld_done              <= 1'b1;
          end else begin
            z_corr_memory_wr_addr <= z_corr_memory_wr_addr + AW'(1);
          end
        end
`endif
        ST_DONE: begin
          ld_done <= 1'b0;
          ld_busy <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drive_z_corr_table_loader.sv
// Scoreboard bench for drive_z_corr_table_loader: expected row writes are queued as
// stimulus completes each row and compared when wr_en is observed.
module tb_drive_z_corr_table_loader;

  localparam int unsigned DW = 384;

  typedef struct {
    logic [3:0]    addr;
    logic [1:0]    sel;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_start;
  logic [1:0]    ld_bank_sel;
  logic [3:0]    ld_base_addr;
  logic [4:0]    ld_num_entry;
  logic          coef_valid;
  logic          coef_ready;
  logic [11:0]   coef_data;
  logic [1:0]    wr_sel;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          ld_busy;
  logic          ld_done;
`ifdef DRIVE_Z_CORR_LOADER_CLEAR_EN
  logic          ld_clear;
`endif

  drive_z_corr_table_loader dut (
    .clk                   (clk),
    .rst                   (rst),
    .ld_start              (ld_start),
`ifdef DRIVE_Z_CORR_LOADER_CLEAR_EN
    .ld_clear              (ld_clear),
`endif
    .ld_bank_sel           (ld_bank_sel),
    .ld_base_addr          (ld_base_addr),
    .ld_num_entry          (ld_num_entry),
    .coef_valid            (coef_valid),
    .coef_ready            (coef_ready),
    .coef_data             (coef_data),
    .z_corr_memory_wr_sel  (wr_sel),
    .z_corr_memory_wr_en   (wr_en),
    .z_corr_memory_wr_addr (wr_addr),
    .z_corr_memory_wr_data (wr_data),
    .ld_busy               (ld_busy),
    .ld_done               (ld_done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  int   last_wr_cyc = 0;
  int   last_done_cyc = 0;
  int   last_acc_cyc = 0;
  int   start_cyc = 0;
  bit   ready_seen = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [11:0] words [32];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ld_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (coef_ready) ready_seen = 1;
    if (wr_en) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      check("ready_in_write", DW'(coef_ready), DW'(0));
      if (exp_q.size() == 0) begin
        check("unexpected_wr", DW'(1), DW'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", DW'(wr_addr), DW'(mon_e.addr));
        check("wr_sel", DW'(wr_sel), DW'(mon_e.sel));
        check("wr_data", wr_data, mon_e.data);
      end
    end else begin
      check("sel_idle", DW'(wr_sel), DW'(0));
    end
  end

  function automatic logic [DW-1:0] row_of_words();
    logic [DW-1:0] r = '0;
    for (int q = 0; q < 32; q++) r[q*12 +: 12] = words[q];
    return r;
  endfunction

  task automatic fill_words(input bit counting);
    for (int q = 0; q < 32; q++) words[q] = counting ? 12'(q + 1) : 12'($urandom);
  endtask

  task automatic start(input logic [1:0] mask, input logic [3:0] base, input logic [4:0] num, input bit clr);
    @(negedge clk);
    ld_bank_sel  = mask;
    ld_base_addr = base;
    ld_num_entry = num;
`ifdef DRIVE_Z_CORR_LOADER_CLEAR_EN
    ld_clear = clr;
`else
    if (clr) check("clear_unsupported", DW'(0), DW'(1));
`endif
    ld_start  = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    ld_start = 1'b0;
`ifdef DRIVE_Z_CORR_LOADER_CLEAR_EN
    ld_clear = 1'b0;
`endif
  endtask

  // Drives words[from..to-1]; the row expectation is queued once word 31 is accepted.
  task automatic send_words(input int from, input int to, input int duty,
                            input logic [3:0] addr, input logic [1:0] sel);
    int i = from;
    int guard = 0;
    while (i < to && guard < 5000) begin
      @(negedge clk);
      guard++;
      coef_valid = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
      coef_data  = words[i];
      if (coef_valid && coef_ready) begin
        if (i == 31) begin
          exp_q.push_back('{addr, sel, row_of_words()});
          last_acc_cyc = cyc;
        end
        i++;
      end
    end
    check("send_complete", DW'(i), DW'(to));
  endtask

  task automatic run_load(input logic [1:0] mask, input logic [3:0] base, input logic [4:0] num,
                          input int duty, input bit counting);
    int nrows;
    nrows = (mask == 0 || num == 0) ? 0 : ((num > 16) ? 16 : int'(num));
    start(mask, base, num, 1'b0);
    for (int r = 0; r < nrows; r++) begin
      fill_words(counting);
      send_words(0, 32, duty, 4'(int'(base) + r), mask);
    end
    @(negedge clk);
    coef_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int k = 0;
    while (done_cnt == prev && k < 1000) begin
      @(posedge clk);
      k++;
    end
    check("done_seen", DW'(done_cnt), DW'(prev + 1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, DW'(coef_ready), DW'(0));
    check({tag, "_sel"}, DW'(wr_sel), DW'(0));
    check({tag, "_en"}, DW'(wr_en), DW'(0));
    check({tag, "_addr"}, DW'(wr_addr), DW'(0));
    check({tag, "_data"}, wr_data, DW'(0));
    check({tag, "_busy"}, DW'(ld_busy), DW'(0));
    check({tag, "_done"}, DW'(ld_done), DW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int wc, dc;
    rst = 1'b1; ld_start = 1'b0; ld_bank_sel = '0; ld_base_addr = '0; ld_num_entry = '0;
    coef_valid = 1'b0; coef_data = '0;
`ifdef DRIVE_Z_CORR_LOADER_CLEAR_EN
    ld_clear = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // single row, counting pattern, back-to-back
    wc = wr_cnt; dc = done_cnt;
    run_load(2'b01, 4'd3, 5'd1, 100, 1'b1);
    wait_done(dc);
    check("t1_wr_count", DW'(wr_cnt - wc), DW'(1));
    check("t1_wr_latency", DW'(last_wr_cyc), DW'(last_acc_cyc + 1));
    check("t1_done_latency", DW'(last_done_cyc), DW'(last_acc_cyc + 2));
    @(negedge clk);
    check("t1_busy_after", DW'(ld_busy), DW'(0));

    // broadcast with address wrap
    wc = wr_cnt; dc = done_cnt;
    run_load(2'b11, 4'd14, 5'd4, 100, 1'b0);
    wait_done(dc);
    check("t2_wr_count", DW'(wr_cnt - wc), DW'(4));
    check("t2_queue_empty", DW'(exp_q.size()), DW'(0));

    // backpressure
    wc = wr_cnt; dc = done_cnt;
    run_load(2'b01, 4'd3, 5'd1, 30, 1'b1);
    wait_done(dc);
    check("t3_wr_count", DW'(wr_cnt - wc), DW'(1));
    check("t3_done_latency", DW'(last_done_cyc), DW'(last_acc_cyc + 2));

    // degenerate starts
    wc = wr_cnt; dc = done_cnt; ready_seen = 0;
    run_load(2'b01, 4'd2, 5'd0, 100, 1'b0);
    wait_done(dc);
    check("t4_num0_done", DW'(last_done_cyc), DW'(start_cyc + 1));
    check("t4_num0_wr", DW'(wr_cnt - wc), DW'(0));
    check("t4_num0_ready", DW'(ready_seen), DW'(0));
    wc = wr_cnt; dc = done_cnt; ready_seen = 0;
    run_load(2'b00, 4'd2, 5'd5, 100, 1'b0);
    wait_done(dc);
    check("t4_mask0_done", DW'(last_done_cyc), DW'(start_cyc + 1));
    check("t4_mask0_wr", DW'(wr_cnt - wc), DW'(0));
    check("t4_mask0_ready", DW'(ready_seen), DW'(0));
    wc = wr_cnt; dc = done_cnt;
    run_load(2'b10, 4'd7, 5'd20, 100, 1'b0);
    wait_done(dc);
    check("t4_clamp_wr", DW'(wr_cnt - wc), DW'(16));

    // ld_start during FILL is ignored
    wc = wr_cnt; dc = done_cnt;
    start(2'b01, 4'd5, 5'd1, 1'b0);
    fill_words(1'b0);
    send_words(0, 5, 100, 4'd5, 2'b01);
    @(negedge clk);
    coef_valid = 1'b0; ld_start = 1'b1;
    ld_bank_sel = 2'b10; ld_base_addr = 4'd9; ld_num_entry = 5'd3;
    @(negedge clk);
    ld_start = 1'b0;
    check("t5_busy", DW'(ld_busy), DW'(1));
    send_words(5, 32, 100, 4'd5, 2'b01);
    @(negedge clk);
    coef_valid = 1'b0;
    wait_done(dc);
    check("t5_wr_count", DW'(wr_cnt - wc), DW'(1));

    // reset after word 10 aborts the run
    start(2'b01, 4'd2, 5'd1, 1'b0);
    fill_words(1'b0);
    send_words(0, 10, 100, 4'd2, 2'b01);
    @(negedge clk);
    coef_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_all_zero("t5_rst");
    rst = 1'b0;
    wc = wr_cnt; dc = done_cnt;
    repeat (40) @(negedge clk);
    check("t5_rst_wr", DW'(wr_cnt - wc), DW'(0));
    check("t5_rst_done", DW'(done_cnt - dc), DW'(0));

`ifdef DRIVE_Z_CORR_LOADER_CLEAR_EN
    wc = wr_cnt; dc = done_cnt; ready_seen = 0;
    for (int a = 0; a < 16; a++) exp_q.push_back('{4'(a), 2'b10, '0});
    start(2'b10, 4'd0, 5'd16, 1'b1);
    wait_done(dc);
    check("t6_wr_count", DW'(wr_cnt - wc), DW'(16));
    check("t6_last_wr", DW'(last_wr_cyc), DW'(start_cyc + 16));
    check("t6_done", DW'(last_done_cyc), DW'(start_cyc + 17));
    check("t6_ready", DW'(ready_seen), DW'(0));
`endif

    check("final_queue_empty", DW'(exp_q.size()), DW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
